// File: rtl/alu_pkg.sv
// Shared encodings for the RV32I decode stage: ALU op codes, opcodes,
// operand-select and instruction-kind encodings, and the decoded-field record.
package alu_pkg;

   localparam logic [3:0] ALU_EQ  = 4'd0;
   localparam logic [3:0] ALU_NE  = 4'd1;
   localparam logic [3:0] ALU_LT  = 4'd2;
   localparam logic [3:0] ALU_GE  = 4'd3;
   localparam logic [3:0] ALU_LTU = 4'd4;
   localparam logic [3:0] ALU_GEU = 4'd5;
   localparam logic [3:0] ALU_ADD = 4'd6;
   localparam logic [3:0] ALU_XOR = 4'd7;
   localparam logic [3:0] ALU_OR  = 4'd8;
   localparam logic [3:0] ALU_AND = 4'd9;
   localparam logic [3:0] ALU_SUB = 4'd10;
   localparam logic [3:0] ALU_SLL = 4'd11;
   localparam logic [3:0] ALU_SRL = 4'd12;
   localparam logic [3:0] ALU_SRA = 4'd13;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [1:0] SRC1_RS1  = 2'b00;
   localparam logic [1:0] SRC1_PC   = 2'b01;
   localparam logic [1:0] SRC1_ZERO = 2'b10;
   localparam logic       SRC2_RS2  = 1'b0;
   localparam logic       SRC2_IMM  = 1'b1;

   localparam logic [2:0] KIND_ALU    = 3'd0;
   localparam logic [2:0] KIND_BRANCH = 3'd1;
   localparam logic [2:0] KIND_LOAD   = 3'd2;
   localparam logic [2:0] KIND_STORE  = 3'd3;
   localparam logic [2:0] KIND_JAL    = 3'd4;
   localparam logic [2:0] KIND_JALR   = 3'd5;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_t;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic [31:0] imm;
      logic [1:0]  src1_sel;
      logic        src2_sel;
      logic [2:0]  kind;
      logic        illegal;
   } dec_t;

   // Register/immediate arithmetic op from funct3; alt selects SUB/SRA.
   function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_LT;
         3'b011:  op = ALU_LTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave: the stage's view; master: the surrounding pipeline's view.
interface alu_decode_stage_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [3:0]  out_alu_op;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [31:0] out_imm;
   logic [1:0]  out_src1_sel;
   logic        out_src2_sel;
   logic [2:0]  out_kind;
   logic        out_illegal;

   modport slave (
      input  flush, in_valid, in_insn, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
             out_rd_we, out_imm, out_src1_sel, out_src2_sel, out_kind, out_illegal
   );

   modport master (
      output flush, in_valid, in_insn, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_alu_op, out_rs1, out_rs2, out_rd,
             out_rd_we, out_imm, out_src1_sel, out_src2_sel, out_kind, out_illegal
   );
endinterface

// File: rtl/rv32i_insn_decode.sv
// Combinational RV32I instruction-to-ALU-control decoder.
// Optional ILLEGAL_INSN_EN: flag unrecognised opcodes and reserved funct3/funct7.
// Any bad encoding decodes as a nop (ADD, no writeback) in both builds.
module rv32i_insn_decode
   import alu_pkg::*;
(
   input  logic [31:0] insn,
   output dec_t        dec
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        known, reserved, writes;
   dec_t        d;

   assign opc   = insn[6:0];
   assign f3    = insn[14:12];
   assign f7    = insn[31:25];
   assign imm_i = {{20{insn[31]}}, insn[31:20]};
   assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u = {insn[31:12], 12'b0};
   assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

   // Field extraction per opcode, then nop-ify anything unrecognised or reserved.
   always_comb begin
      d        = '0;
      d.alu_op = ALU_ADD;
      known    = 1'b1;
      reserved = 1'b0;
      writes   = 1'b0;
      case (opc)
         OPC_OP: begin
            d.rs1    = insn[19:15];
            d.rs2    = insn[24:20];
            d.rd     = insn[11:7];
            d.alu_op = arith_op(f3, insn[30]);
            writes   = 1'b1;
            reserved = !((f7 == 7'b0000000) ||
                         (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            d.rs1      = insn[19:15];
            d.rd       = insn[11:7];
            d.src2_sel = SRC2_IMM;
            d.alu_op   = arith_op(f3, (f3 == 3'b101) && insn[30]);
            writes     = 1'b1;
            if (f3 == 3'b001 || f3 == 3'b101) begin
               d.imm    = {27'b0, insn[24:20]};
               reserved = (f3 == 3'b001) ? (f7 != 7'b0000000)
                                         : !(f7 == 7'b0000000 || f7 == 7'b0100000);
            end else begin
               d.imm = imm_i;
            end
         end
         OPC_BRANCH: begin
            d.rs1  = insn[19:15];
            d.rs2  = insn[24:20];
            d.imm  = imm_b;
            d.kind = KIND_BRANCH;
            case (f3)
               3'b000:  d.alu_op = ALU_EQ;
               3'b001:  d.alu_op = ALU_NE;
               3'b100:  d.alu_op = ALU_LT;
               3'b101:  d.alu_op = ALU_GE;
               3'b110:  d.alu_op = ALU_LTU;
               3'b111:  d.alu_op = ALU_GEU;
               default: reserved = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            d.rs1      = insn[19:15];
            d.rd       = insn[11:7];
            d.imm      = imm_i;
            d.src2_sel = SRC2_IMM;
            d.kind     = KIND_LOAD;
            writes     = 1'b1;
            reserved   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            d.rs1      = insn[19:15];
            d.rs2      = insn[24:20];
            d.imm      = imm_s;
            d.src2_sel = SRC2_IMM;
            d.kind     = KIND_STORE;
            reserved   = (f3 > 3'b010);
         end
         OPC_JALR: begin
            d.rs1      = insn[19:15];
            d.rd       = insn[11:7];
            d.imm      = imm_i;
            d.src2_sel = SRC2_IMM;
            d.kind     = KIND_JALR;
            writes     = 1'b1;
            reserved   = (f3 != 3'b000);
         end
         OPC_JAL: begin
            d.rd       = insn[11:7];
            d.imm      = imm_j;
            d.src1_sel = SRC1_PC;
            d.src2_sel = SRC2_IMM;
            d.kind     = KIND_JAL;
            writes     = 1'b1;
         end
         OPC_LUI: begin
            d.rd       = insn[11:7];
            d.imm      = imm_u;
            d.src1_sel = SRC1_ZERO;
            d.src2_sel = SRC2_IMM;
            writes     = 1'b1;
         end
         OPC_AUIPC: begin
            d.rd       = insn[11:7];
            d.imm      = imm_u;
            d.src1_sel = SRC1_PC;
            d.src2_sel = SRC2_IMM;
            writes     = 1'b1;
         end
         default: known = 1'b0;
      endcase

      if (!known || reserved) begin
         d        = '0;
         d.alu_op = ALU_ADD;
         writes   = 1'b0;
      end
      d.rd_we = writes && (d.rd != 5'd0);
`ifdef ILLEGAL_INSN_EN
      d.illegal = !known || reserved;
`else
      d.illegal = 1'b0;
`endif
      dec = d;
   end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: decodes fetched instructions and presents ALU control
// fields from a registered two-entry (main + skid) buffer.
// Optional ILLEGAL_INSN_EN enables the out_illegal flag in the decoder.
//
//   state    | meaning
//   ST_EMPTY | no entry buffered, out_valid=0
//   ST_ONE   | main holds the presented entry, skid empty
//   ST_TWO   | main presented, skid holds the next entry, in_ready=0
module alu_decode_stage
   import alu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   alu_decode_stage_if.slave  bus
);

   stage_state_t    state;
   dec_t            dec_in, main_d, skid_d;
   logic [XLEN-1:0] main_pc, skid_pc;
   logic            in_ready_r, out_valid_r;
   logic            accept, pop;

   rv32i_insn_decode u_dec (
      .insn (bus.in_insn),
      .dec  (dec_in)
   );

   assign accept = bus.in_valid && in_ready_r;
   assign pop    = out_valid_r && bus.out_ready;

   // Buffer FSM; ready/valid are registered alongside the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_EMPTY;
         main_d      <= '0;
         main_pc     <= RESET_PC;
         skid_d      <= '0;
         skid_pc     <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else if (bus.flush) begin
         state       <= ST_EMPTY;
         main_d      <= '0;
         main_pc     <= RESET_PC;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_d      <= dec_in;
                  main_pc     <= bus.in_pc;
                  out_valid_r <= 1'b1;
                  state       <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !pop) begin
                  skid_d     <= dec_in;
                  skid_pc    <= bus.in_pc;
                  in_ready_r <= 1'b0;
                  state      <= ST_TWO;
               end else if (accept && pop) begin
                  main_d  <= dec_in;
                  main_pc <= bus.in_pc;
               end else if (pop) begin
                  main_d      <= '0;
                  main_pc     <= RESET_PC;
                  out_valid_r <= 1'b0;
                  state       <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  main_d     <= skid_d;
                  main_pc    <= skid_pc;
                  in_ready_r <= 1'b1;
                  state      <= ST_ONE;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready_r;
   assign bus.out_valid    = out_valid_r;
   assign bus.out_pc       = main_pc;
   assign bus.out_alu_op   = main_d.alu_op;
   assign bus.out_rs1      = main_d.rs1;
   assign bus.out_rs2      = main_d.rs2;
   assign bus.out_rd       = main_d.rd;
   assign bus.out_rd_we    = main_d.rd_we;
   assign bus.out_imm      = main_d.imm;
   assign bus.out_src1_sel = main_d.src1_sel;
   assign bus.out_src2_sel = main_d.src2_sel;
   assign bus.out_kind     = main_d.kind;
   assign bus.out_illegal  = main_d.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, skid ordering,
// flush, async reset and the illegal-instruction flag.
module tb_alu_decode_stage;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   alu_decode_stage_if bus ();

   alu_decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_illegal;
`ifdef ILLEGAL_INSN_EN
      exp_illegal = 1'b1;
`else
      exp_illegal = 1'b0;
`endif
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_insn = '0;
      bus.in_pc = '0;
      bus.out_ready = 1'b0;
      tick();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_alu_op", bus.out_alu_op, 0);
      chk("rst_imm", bus.out_imm, 0);
      rst = 1'b0;
      tick();

      // Streaming decode vectors, execute always ready
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_insn = 32'h00500093; bus.in_pc = 32'h100;  // ADDI x1,x0,5
      tick();
      chk("addi_valid", bus.out_valid, 1);
      chk("addi_op", bus.out_alu_op, 6);
      chk("addi_rd", bus.out_rd, 1);
      chk("addi_rs1", bus.out_rs1, 0);
      chk("addi_imm", bus.out_imm, 5);
      chk("addi_src2", bus.out_src2_sel, 1);
      chk("addi_rdwe", bus.out_rd_we, 1);
      chk("addi_pc", bus.out_pc, 32'h100);

      bus.in_insn = 32'h402081B3; bus.in_pc = 32'h104;  // SUB x3,x1,x2
      tick();
      chk("sub_op", bus.out_alu_op, 10);
      chk("sub_rs1", bus.out_rs1, 1);
      chk("sub_rs2", bus.out_rs2, 2);
      chk("sub_rd", bus.out_rd, 3);
      chk("sub_src2", bus.out_src2_sel, 0);
      chk("sub_pc", bus.out_pc, 32'h104);

      bus.in_insn = 32'h40335293; bus.in_pc = 32'h108;  // SRAI x5,x6,3
      tick();
      chk("srai_op", bus.out_alu_op, 13);
      chk("srai_shamt", {27'b0, bus.out_imm[4:0]}, 3);
      chk("srai_rs1", bus.out_rs1, 6);
      chk("srai_rd", bus.out_rd, 5);

      bus.in_insn = 32'h0020E463; bus.in_pc = 32'h10C;  // BLTU x1,x2,+8
      tick();
      chk("bltu_op", bus.out_alu_op, 4);
      chk("bltu_kind", bus.out_kind, 1);
      chk("bltu_imm", bus.out_imm, 8);
      chk("bltu_rdwe", bus.out_rd_we, 0);
      chk("bltu_src2", bus.out_src2_sel, 0);

      bus.in_insn = 32'h123453B7; bus.in_pc = 32'h110;  // LUI x7,0x12345
      tick();
      chk("lui_imm", bus.out_imm, 32'h12345000);
      chk("lui_src1", bus.out_src1_sel, 2);
      chk("lui_op", bus.out_alu_op, 6);

      bus.in_insn = 32'hFFFFF417; bus.in_pc = 32'h114;  // AUIPC x8,0xFFFFF
      tick();
      chk("auipc_imm", bus.out_imm, 32'hFFFFF000);
      chk("auipc_src1", bus.out_src1_sel, 1);

      bus.in_insn = 32'hFFDFF0EF; bus.in_pc = 32'h118;  // JAL x1,-4
      tick();
      chk("jal_imm", bus.out_imm, 32'hFFFFFFFC);
      chk("jal_kind", bus.out_kind, 4);
      chk("jal_rdwe", bus.out_rd_we, 1);

      bus.in_insn = 32'hFE20AC23; bus.in_pc = 32'h11C;  // SW x2,-8(x1)
      tick();
      chk("sw_imm", bus.out_imm, 32'hFFFFFFF8);
      chk("sw_kind", bus.out_kind, 3);
      chk("sw_rdwe", bus.out_rd_we, 0);
      chk("sw_rs2", bus.out_rs2, 2);

      bus.in_insn = 32'h00000000; bus.in_pc = 32'h120;  // unrecognised
      tick();
      chk("zero_illegal", bus.out_illegal, exp_illegal);
      chk("zero_rdwe", bus.out_rd_we, 0);
      chk("zero_op", bus.out_alu_op, 6);
      chk("zero_kind", bus.out_kind, 0);

      bus.in_valid = 1'b0;
      tick();
      chk("drain_valid", bus.out_valid, 0);
      chk("drain_pc", bus.out_pc, 0);

      // Skid: execute stalled, push A, B, C back-to-back
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_insn = 32'h00100093; bus.in_pc = 32'h200;  // A
      tick();
      chk("skid_a_valid", bus.out_valid, 1);
      chk("skid_a_ready", bus.in_ready, 1);
      bus.in_insn = 32'h00200113; bus.in_pc = 32'h204;  // B
      tick();
      chk("skid_b_ready", bus.in_ready, 0);
      chk("skid_b_hold", bus.out_pc, 32'h200);
      bus.in_insn = 32'h00300193; bus.in_pc = 32'h208;  // C (stalled)
      tick();
      chk("skid_c_ready", bus.in_ready, 0);
      chk("skid_hold_pc", bus.out_pc, 32'h200);
      chk("skid_hold_imm", bus.out_imm, 1);
      bus.out_ready = 1'b1;
      tick();
      chk("skid_pop_b_pc", bus.out_pc, 32'h204);
      chk("skid_pop_b_imm", bus.out_imm, 2);
      chk("skid_pop_ready", bus.in_ready, 1);
      tick();
      chk("skid_c_pc", bus.out_pc, 32'h208);
      chk("skid_c_imm", bus.out_imm, 3);
      chk("skid_c_rd", bus.out_rd, 3);
      bus.in_valid = 1'b0;
      tick();
      chk("skid_empty", bus.out_valid, 0);

      // Flush while full, with a fresh instruction offered the same cycle
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_insn = 32'h00100093; bus.in_pc = 32'h300;
      tick();
      bus.in_insn = 32'h00200113; bus.in_pc = 32'h304;
      tick();
      chk("flush_pre_ready", bus.in_ready, 0);
      bus.flush = 1'b1;
      bus.in_insn = 32'h00300193; bus.in_pc = 32'h308;
      tick();
      chk("flush_valid", bus.out_valid, 0);
      chk("flush_ready", bus.in_ready, 1);
      chk("flush_pc", bus.out_pc, 0);
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_quiet", bus.out_valid, 0);
      end

      // Async reset mid-operation drops the buffered entry immediately
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      bus.in_insn = 32'h00500093; bus.in_pc = 32'h400;
      tick();
      chk("arst_pre_valid", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_pc", bus.out_pc, 0);
      chk("arst_ready", bus.in_ready, 1);
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
